reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Reservation-station bank sitting directly upstream of the 3-cycle add/sub/address functional unit in the Tomasulo core.
- Accepts issued instructions with operand values or producer tags, and snoops the common data bus (CDB) to resolve pending operands.
- Dispatches one ready entry at a time to the functional unit over the start/busy/confirmacao handshake.
- Holds the unit's operand inputs stable until the unit confirms completion.

Parameters:
- NUM_ENTRIES, 3, number of station entries (1..6).
- BASE_TAG, 1, tag of entry 0; entry i carries tag BASE_TAG+i; tag 0 is reserved as "no producer".
- DATA_W, 16, operand/CDB data width.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- CLR  in  1  synchronous active-high reset.
- issue_valid  in  1  issue request this cycle.
- issue_op  in  3  opcode: 001 add, 010 sub, 011 load addr, 100 store addr.
- issue_vj, issue_vk  in  DATA_W  operand values, valid when matching q is 0.
- issue_qj, issue_qk  in  3  producer tags, 0 = value already present.
- issue_tag  out  3  tag the next issue will receive (lowest free entry); 0 when full.
- full  out  1  no free entry; issue is ignored while high.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  3  producing tag on CDB.
- cdb_data  in  DATA_W  broadcast value.
- start  out  1  one-cycle dispatch pulse to the functional unit.
- ID_out  out  3  tag of dispatched entry.
- Dado1, Dado2  out  DATA_W  Vj/Vk of dispatched entry.
- op  out  3  opcode of dispatched entry.
- busy  in  1  functional unit busy.
- confirmacao  in  1  functional unit result done; stays high until the next start.

Behaviour:
- Reset (CLR=1 at an edge):
  - All entries invalid; in_flight=0.
  - start=0, ID_out=0, Dado1=0, Dado2=0, op=0.
  - full=0; issue_tag=BASE_TAG.
  - Reset mid-operation abandons any in-flight entry; a stale confirmacao after reset is ignored because in_flight=0.
- Entry state: valid, op, vj, vk, qj, qk, dispatched.
- Issue:
  - Occurs when issue_valid=1 and full=0.
  - Writes the lowest-index free entry.
  - full and issue_tag derive from registered state only. An entry freed in the same cycle cannot be reused until the next cycle.
- CDB snoop: on cdb_valid, every valid entry with qj==cdb_tag (cdb_tag≠0) loads vj←cdb_data and qj←0; same for k.
- Simultaneous issue and CDB: if an issued operand's q equals cdb_tag, the new entry captures cdb_data directly and stores q=0.
- Ready condition: valid, not dispatched, qj=0, qk=0.
- Dispatch FSM, states IDLE and WAIT:
  - IDLE → WAIT when any entry is ready and busy=0.
    - Selects the lowest-index ready entry.
    - Drives start=1 for exactly one cycle.
    - Registers ID_out, Dado1, Dado2, op from that entry.
    - Marks the entry dispatched and sets in_flight=1.
  - WAIT:
    - start=0; ID_out, Dado1, Dado2, op held constant, since the unit samples operands in its third cycle.
    - On the first edge with confirmacao=1, frees the dispatched entry, clears in_flight, and returns to IDLE.
  - The earliest next start is the cycle after return to IDLE, so the minimum dispatch-to-dispatch interval is 4 cycles.
  - A confirmacao already high on entry to WAIT (left over from the previous op) is not accepted. Completion requires confirmacao to be observed low after start, then high.
- An entry that becomes ready through a CDB snoop in cycle n is dispatchable in cycle n+1, not combinationally.
- cdb_tag equal to a station's own in-flight tag does not free the entry; only confirmacao does.

Decomposition:
- Shared package (tomasulo_pkg):
  - TAG_W=3, TAG_NONE=0.
  - Opcode constants OP_ADD=001, OP_SUB=010, OP_LD=011, OP_ST=100.
  - DATA_W.
  - Entry struct {valid, dispatched, op, vj, vk, qj, qk}.
- One sub-module, rs_entry: holds a single entry and implements its issue write, CDB snoop, ready flag and free logic.
- The top level contains the priority encoders (free and ready) and the dispatch FSM.

Test Plan:
- Reset, then issue add vj=5 vk=7 qj=qk=0 → start pulses next cycle with ID_out=1, Dado1=5, Dado2=7, op=001; outputs held until confirmacao; entry freed the following edge.
- Issue sub with qj=3, vk=2 → no start; cdb_valid, tag 3, data 10 → start next cycle with Dado1=10, Dado2=2, op=010.
- Fill 3 entries with pending tags → full=1, issue_tag=0; a 4th issue_valid is dropped; a CDB broadcast releases them in index order 1, 2, 3, one per handshake, each ≥4 cycles apart.
- Issue with qj=4 in the same cycle as cdb_valid, tag 4, data 0x1234 → entry stores vj=0x1234, qj=0 and dispatches.
- Hold busy=1 externally with a ready entry → no start until busy=0.
- Assert CLR during WAIT → all outputs zero next cycle; a subsequent confirmacao frees nothing; fresh issue gets tag 1.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the Tomasulo core.
// Tags are 3 bits wide; tag 0 means "no producer".
package tomasulo_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 16;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_LD   = 3'b011,
        OP_ST   = 3'b100
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } disp_state_e;

    typedef struct packed {
        logic              valid;
        logic              dispatched;
        op_e               op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qj;
        logic [TAG_W-1:0]  qk;
    } rs_entry_t;

endpackage

// File: rtl/reservation_station_if.sv
// Issue, CDB and functional-unit signals of one reservation station.
// slave is the station's view, master the environment's.
interface reservation_station_if #(
    parameter int DATA_W = tomasulo_pkg::DATA_W
) ();
    localparam int TW = tomasulo_pkg::TAG_W;

    logic              issue_valid;
    logic [2:0]        issue_op;
    logic [DATA_W-1:0] issue_vj;
    logic [DATA_W-1:0] issue_vk;
    logic [TW-1:0]     issue_qj;
    logic [TW-1:0]     issue_qk;
    logic [TW-1:0]     issue_tag;
    logic              full;

    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic              start;
    logic [TW-1:0]     ID_out;
    logic [DATA_W-1:0] Dado1;
    logic [DATA_W-1:0] Dado2;
    logic [2:0]        op;
    logic              busy;
    logic              confirmacao;

    modport slave (
        input  issue_valid, issue_op,
        input  issue_vj, issue_vk,
        input  issue_qj, issue_qk,
        output issue_tag, full,
        input  cdb_valid, cdb_tag, cdb_data,
        output start, ID_out,
        output Dado1, Dado2, op,
        input  busy, confirmacao
    );

    modport master (
        output issue_valid, issue_op,
        output issue_vj, issue_vk,
        output issue_qj, issue_qk,
        input  issue_tag, full,
        output cdb_valid, cdb_tag, cdb_data,
        input  start, ID_out,
        input  Dado1, Dado2, op,
        output busy, confirmacao
    );

endinterface

// File: rtl/rs_entry.sv
// One reservation-station entry: issue write with CDB bypass,
// CDB snoop, dispatched marker, ready flag and free.
module rs_entry
    import tomasulo_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] vj_i,
    input  logic [DATA_W-1:0] vk_i,
    input  logic [TAG_W-1:0]  qj_i,
    input  logic [TAG_W-1:0]  qk_i,
    input  logic              cdb_valid_i,
    input  logic [TAG_W-1:0]  cdb_tag_i,
    input  logic [DATA_W-1:0] cdb_data_i,
    input  logic              dispatch_i,
    input  logic              free_i,
    output logic              valid_o,
    output logic [2:0]        op_o,
    output logic [DATA_W-1:0] vj_o,
    output logic [DATA_W-1:0] vk_o,
    output logic              ready_o
);

    rs_entry_t entry_q, entry_d;

    logic cdb_live;
    logic iss_hit_j, iss_hit_k;
    logic snp_hit_j, snp_hit_k;

    assign cdb_live  = cdb_valid_i && (cdb_tag_i != TAG_NONE);
    assign iss_hit_j = cdb_live && (qj_i == cdb_tag_i);
    assign iss_hit_k = cdb_live && (qk_i == cdb_tag_i);
    assign snp_hit_j = cdb_live && (entry_q.qj == cdb_tag_i);
    assign snp_hit_k = cdb_live && (entry_q.qk == cdb_tag_i);

    always_comb begin
        entry_d = entry_q;
        if (free_i) begin
            entry_d = '0;
        end else if (we_i) begin
            entry_d.valid      = 1'b1;
            entry_d.dispatched = 1'b0;
            entry_d.op         = op_e'(op_i);
            entry_d.vj = iss_hit_j ? cdb_data_i : vj_i;
            entry_d.qj = iss_hit_j ? TAG_NONE : qj_i;
            entry_d.vk = iss_hit_k ? cdb_data_i : vk_i;
            entry_d.qk = iss_hit_k ? TAG_NONE : qk_i;
        end else if (entry_q.valid) begin
            if (snp_hit_j) begin
                entry_d.vj = cdb_data_i;
                entry_d.qj = TAG_NONE;
            end
            if (snp_hit_k) begin
                entry_d.vk = cdb_data_i;
                entry_d.qk = TAG_NONE;
            end
            if (dispatch_i) begin
                entry_d.dispatched = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign valid_o = entry_q.valid;
    assign op_o    = entry_q.op;
    assign vj_o    = entry_q.vj;
    assign vk_o    = entry_q.vk;
    assign ready_o = entry_q.valid && !entry_q.dispatched &&
                     (entry_q.qj == TAG_NONE) &&
                     (entry_q.qk == TAG_NONE);

endmodule

// File: rtl/reservation_station.sv
// Reservation-station bank: free/ready priority encoders and the
// start/confirmacao dispatch FSM in front of the functional unit.
module reservation_station
    import tomasulo_pkg::*;
#(
    parameter int NUM_ENTRIES = 3,
    parameter int BASE_TAG    = 1,
    parameter int DATA_W      = tomasulo_pkg::DATA_W
) (
    input logic                 CLK,
    input logic                 CLR,
    reservation_station_if.slave rs
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic [NUM_ENTRIES-1:0] valid, ready, we, dispatch, free;
    logic [2:0]             e_op [NUM_ENTRIES];
    logic [DATA_W-1:0]      e_vj [NUM_ENTRIES];
    logic [DATA_W-1:0]      e_vk [NUM_ENTRIES];

    logic             free_found, ready_found;
    logic [IDX_W-1:0] free_idx, ready_idx;

    disp_state_e       state_q, state_d;
    logic              seen_low_q, seen_low_d;
    logic [IDX_W-1:0]  disp_idx_q, disp_idx_d;
    logic              start_q, start_d;
    logic [TAG_W-1:0]  id_q, id_d;
    logic [DATA_W-1:0] d1_q, d1_d;
    logic [DATA_W-1:0] d2_q, d2_d;
    logic [2:0]        op_q, op_d;

    logic go, done;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_ent
        rs_entry u_ent (
            .clk_i       (CLK),
            .rst_i       (CLR),
            .we_i        (we[g]),
            .op_i        (rs.issue_op),
            .vj_i        (rs.issue_vj),
            .vk_i        (rs.issue_vk),
            .qj_i        (rs.issue_qj),
            .qk_i        (rs.issue_qk),
            .cdb_valid_i (rs.cdb_valid),
            .cdb_tag_i   (rs.cdb_tag),
            .cdb_data_i  (rs.cdb_data),
            .dispatch_i  (dispatch[g]),
            .free_i      (free[g]),
            .valid_o     (valid[g]),
            .op_o        (e_op[g]),
            .vj_o        (e_vj[g]),
            .vk_o        (e_vk[g]),
            .ready_o     (ready[g])
        );
        assign we[g] = rs.issue_valid && free_found &&
                       (free_idx == IDX_W'(g));
    end

    // Both encoders see registered state only, so a slot freed this
    // cycle becomes issuable on the next one.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        ready_found = 1'b0;
        ready_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ready[i]) begin
                ready_found = 1'b1;
                ready_idx   = IDX_W'(i);
            end
        end
    end

    assign rs.full      = !free_found;
    assign rs.issue_tag = free_found ?
                          TAG_W'(BASE_TAG) + TAG_W'(free_idx) :
                          TAG_NONE;

    assign go   = (state_q == S_IDLE) && ready_found && !rs.busy;
    assign done = (state_q == S_WAIT) && rs.confirmacao && seen_low_q;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q    <= S_IDLE;
            seen_low_q <= 1'b0;
            disp_idx_q <= '0;
            start_q    <= 1'b0;
            id_q       <= '0;
            d1_q       <= '0;
            d2_q       <= '0;
            op_q       <= '0;
        end else begin
            state_q    <= state_d;
            seen_low_q <= seen_low_d;
            disp_idx_q <= disp_idx_d;
            start_q    <= start_d;
            id_q       <= id_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            op_q       <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (go) state_d = S_WAIT;
            S_WAIT: if (done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A confirmacao still high from the previous op only counts
    // after it has been seen low at least once in WAIT.
    always_comb begin
        start_d    = 1'b0;
        seen_low_d = seen_low_q;
        disp_idx_d = disp_idx_q;
        id_d       = id_q;
        d1_d       = d1_q;
        d2_d       = d2_q;
        op_d       = op_q;
        dispatch   = '0;
        free       = '0;
        if (go) begin
            start_d    = 1'b1;
            seen_low_d = 1'b0;
            disp_idx_d = ready_idx;
            id_d       = TAG_W'(BASE_TAG) + TAG_W'(ready_idx);
            d1_d       = e_vj[ready_idx];
            d2_d       = e_vk[ready_idx];
            op_d       = e_op[ready_idx];
            dispatch[ready_idx] = 1'b1;
        end
        if (state_q == S_WAIT) begin
            if (!rs.confirmacao) seen_low_d = 1'b1;
            if (done) free[disp_idx_q] = 1'b1;
        end
    end

    assign rs.start  = start_q;
    assign rs.ID_out = id_q;
    assign rs.Dado1  = d1_q;
    assign rs.Dado2  = d2_q;
    assign rs.op     = op_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: vector table plus
// hand sequences for snoop, full, bypass, busy and reset.
module tb_reservation_station;
    import tomasulo_pkg::*;

    logic CLK = 1'b0;
    logic CLR;
    always #5 CLK = ~CLK;

    reservation_station_if bus ();

    reservation_station dut (
        .CLK (CLK),
        .CLR (CLR),
        .rs  (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] vj;
        logic [15:0] vk;
        logic [2:0]  e_id;
        logic [15:0] e_d1;
        logic [15:0] e_d2;
        logic [2:0]  e_op;
    } vec_t;

    vec_t tv [5];

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h",
                      nm, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(logic [2:0] o, logic [15:0] vj,
                         logic [15:0] vk, logic [2:0] qj,
                         logic [2:0] qk);
        bus.issue_valid = 1'b1;
        bus.issue_op    = o;
        bus.issue_vj    = vj;
        bus.issue_vk    = vk;
        bus.issue_qj    = qj;
        bus.issue_qk    = qk;
        tick();
        bus.issue_valid = 1'b0;
    endtask

    task automatic cdb(logic [2:0] t, logic [15:0] d);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = t;
        bus.cdb_data  = d;
        tick();
        bus.cdb_valid = 1'b0;
    endtask

    task automatic wait_start(output int at);
        for (int k = 0; k < 20 && !bus.start; k++) tick();
        at = cyc;
        chk("start_seen", 32'(bus.start), 1);
    endtask

    // Models a 3-cycle unit; call with start visible.
    task automatic fu_finish();
        bus.confirmacao = 1'b0;
        tick();
        tick();
        bus.confirmacao = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end");
        $fatal(1);
    end

    initial begin
        int at, prev, cnt;

        tv[0] = '{OP_SUB, 16'd100,  16'd30,   3'd1,
                  16'd100,  16'd30,   OP_SUB};
        tv[1] = '{OP_LD,  16'hFFFF, 16'h0001, 3'd1,
                  16'hFFFF, 16'h0001, OP_LD};
        tv[2] = '{OP_ST,  16'h0000, 16'hABCD, 3'd1,
                  16'h0000, 16'hABCD, OP_ST};
        tv[3] = '{OP_ADD, 16'h8000, 16'h8000, 3'd1,
                  16'h8000, 16'h8000, OP_ADD};
        tv[4] = '{OP_ADD, 16'h1357, 16'h2468, 3'd1,
                  16'h1357, 16'h2468, OP_ADD};

        bus.issue_valid = 0; bus.issue_op = 0;
        bus.issue_vj = 0; bus.issue_vk = 0;
        bus.issue_qj = 0; bus.issue_qk = 0;
        bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
        bus.busy = 0; bus.confirmacao = 0;

        CLR = 1'b1;
        tick();
        tick();
        CLR = 1'b0;
        chk("rst_start", 32'(bus.start), 0);
        chk("rst_id", 32'(bus.ID_out), 0);
        chk("rst_d1", 32'(bus.Dado1), 0);
        chk("rst_d2", 32'(bus.Dado2), 0);
        chk("rst_op", 32'(bus.op), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_tag", 32'(bus.issue_tag), 1);

        issue(OP_ADD, 16'd5, 16'd7, 0, 0);
        chk("A_nostart", 32'(bus.start), 0);
        tick();
        chk("A_start", 32'(bus.start), 1);
        chk("A_id", 32'(bus.ID_out), 1);
        chk("A_d1", 32'(bus.Dado1), 5);
        chk("A_d2", 32'(bus.Dado2), 7);
        chk("A_op", 32'(bus.op), 1);
        tick();
        chk("A_pulse", 32'(bus.start), 0);
        tick();
        chk("A_hold_d1", 32'(bus.Dado1), 5);
        chk("A_hold_id", 32'(bus.ID_out), 1);
        chk("A_busytag", 32'(bus.issue_tag), 2);
        bus.confirmacao = 1'b1;
        tick();
        chk("A_freed", 32'(bus.issue_tag), 1);

        for (int i = 0; i < 5; i++) begin
            issue(tv[i].op, tv[i].vj, tv[i].vk, 0, 0);
            chk("V_tag", 32'(bus.issue_tag), 2);
            wait_start(at);
            chk("V_id", 32'(bus.ID_out), 32'(tv[i].e_id));
            chk("V_d1", 32'(bus.Dado1), 32'(tv[i].e_d1));
            chk("V_d2", 32'(bus.Dado2), 32'(tv[i].e_d2));
            chk("V_op", 32'(bus.op), 32'(tv[i].e_op));
            fu_finish();
            chk("V_freed", 32'(bus.issue_tag), 1);
        end

        issue(OP_SUB, 16'd0, 16'd2, 3'd3, 0);
        tick();
        chk("B_wait", 32'(bus.start), 0);
        cdb(3'd3, 16'd10);
        chk("B_snoop_n", 32'(bus.start), 0);
        tick();
        chk("B_start", 32'(bus.start), 1);
        chk("B_d1", 32'(bus.Dado1), 10);
        chk("B_d2", 32'(bus.Dado2), 2);
        chk("B_op", 32'(bus.op), 2);
        tick();
        tick();
        chk("B_stale", 32'(bus.issue_tag), 2);
        bus.confirmacao = 1'b0;
        tick();
        bus.confirmacao = 1'b1;
        tick();
        chk("B_freed", 32'(bus.issue_tag), 1);

        issue(OP_ADD, 0, 16'd1, 3'd5, 0);
        issue(OP_ADD, 0, 16'd2, 3'd5, 0);
        issue(OP_ADD, 0, 16'd3, 3'd5, 0);
        chk("C_full", 32'(bus.full), 1);
        chk("C_tag0", 32'(bus.issue_tag), 0);
        issue(OP_ADD, 16'd9, 16'd9, 0, 0);
        chk("C_drop", 32'(bus.start), 0);
        chk("C_full2", 32'(bus.full), 1);
        cdb(3'd5, 16'h0050);
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            wait_start(at);
            chk("C_id", 32'(bus.ID_out), 32'(i + 1));
            chk("C_d2", 32'(bus.Dado2), 32'(i + 1));
            chk("C_d1", 32'(bus.Dado1), 32'h50);
            if (i > 0) chk("C_gap", 32'((at - prev) >= 4), 1);
            prev = at;
            fu_finish();
        end
        cnt = 0;
        repeat (6) begin
            if (bus.start) cnt++;
            tick();
        end
        chk("C_no4th", 32'(cnt), 0);
        chk("C_empty", 32'(bus.full), 0);
        chk("C_tag1", 32'(bus.issue_tag), 1);

        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 3'd4;
        bus.cdb_data  = 16'h1234;
        issue(OP_SUB, 16'hDEAD, 16'd1, 3'd4, 0);
        bus.cdb_valid = 1'b0;
        wait_start(at);
        chk("D_d1", 32'(bus.Dado1), 32'h1234);
        chk("D_d2", 32'(bus.Dado2), 1);
        chk("D_op", 32'(bus.op), 2);
        fu_finish();

        bus.busy = 1'b1;
        issue(OP_LD, 16'd3, 16'd4, 0, 0);
        cnt = 0;
        repeat (5) begin
            if (bus.start) cnt++;
            tick();
        end
        chk("E_busy", 32'(cnt), 0);
        bus.busy = 1'b0;
        tick();
        chk("E_start", 32'(bus.start), 1);
        chk("E_d1", 32'(bus.Dado1), 3);
        fu_finish();

        issue(OP_ST, 16'h11, 16'h22, 0, 0);
        wait_start(at);
        tick();
        chk("F_wait", 32'(bus.start), 0);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("F_start", 32'(bus.start), 0);
        chk("F_id", 32'(bus.ID_out), 0);
        chk("F_d1", 32'(bus.Dado1), 0);
        chk("F_d2", 32'(bus.Dado2), 0);
        chk("F_op", 32'(bus.op), 0);
        chk("F_full", 32'(bus.full), 0);
        chk("F_tag", 32'(bus.issue_tag), 1);
        issue(OP_ADD, 0, 0, 3'd6, 0);
        chk("F_tag2", 32'(bus.issue_tag), 2);
        bus.confirmacao = 1'b0;
        tick();
        bus.confirmacao = 1'b1;
        tick();
        tick();
        chk("F_noconf", 32'(bus.issue_tag), 2);
        chk("F_nostart", 32'(bus.start), 0);
        cdb(3'd6, 16'd7);
        wait_start(at);
        chk("F_id1", 32'(bus.ID_out), 1);
        chk("F_d1b", 32'(bus.Dado1), 7);
        fu_finish();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
